// File: rtl/mod_dadda_mul_pkg.sv
// Shared types and sizes for the modified-Booth multiplier datapath.
package mod_dadda_mul_pkg;

  localparam int unsigned NB   = 24;
  localparam int unsigned ROWS = NB / 2 + 1;
  localparam int unsigned PPW  = NB + 1;

  // Row i carries weight 4^i; these match what the Dadda tree consumes.
  typedef logic [ROWS-1:0][PPW-1:0] pp_t;
  typedef logic [ROWS-1:0]          signs_t;

  // One radix-4 digit: magnitude select (one/two) plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

endpackage

// File: rtl/mbe_pp_gen_if.sv
// Operand in / partial-product out handshake bundle.
interface mbe_pp_gen_if;
  import mod_dadda_mul_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [NB-1:0]   a;
  logic [NB-1:0]   b;
  logic            out_valid;
  logic            out_ready;
  pp_t             pp;
  signs_t          signs;

  // Producer of operands / consumer of partial products.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, pp, signs
  );

  // The partial-product generator itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, pp, signs
  );
endinterface

// File: rtl/mbe_pp_gen_booth_row.sv
// One Booth partial-product row: select 0/A/2A, one's-complement when negative.
module booth_row
  import mod_dadda_mul_pkg::*;
(
  input  logic [NB-1:0]  a,
  input  booth_digit_t   dig,
  output logic [PPW-1:0] row,
  output logic           sign
);

  logic [PPW-1:0] mag;

  // Magnitude select then conditional inversion; +1 is added downstream.
  always_comb begin
    mag = '0;
    if (dig.one) begin
      mag = {1'b0, a};
    end else if (dig.two) begin
      mag = {a, 1'b0};
    end
    row  = dig.neg ? ~mag : mag;
    sign = dig.neg;
  end

endmodule

// File: rtl/mbe_pp_gen.sv
// Radix-4 Booth partial-product generator, two-stage elastic pipeline.
// S1 holds A and the encoded multiplier digits; S2 holds the finished rows.
module mbe_pp_gen
  import mod_dadda_mul_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mbe_pp_gen_if.slave bus
);

  logic                     v1_q, v2_q;
  logic [NB-1:0]            a_q;
  booth_digit_t [ROWS-1:0]  dig_q, dig_c;
  pp_t                      pp_q, pp_c;
  signs_t                   signs_q, signs_c;
  logic [2*ROWS:0]          bx;
  logic [2:0]               trip;
  logic                     adv2, in_xfer, out_xfer;

  assign adv2         = v1_q & (~v2_q | bus.out_ready);
  assign bus.in_ready = ~v1_q | adv2;
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = v2_q & bus.out_ready;

  assign bus.out_valid = v2_q;
  assign bus.pp        = pp_q;
  assign bus.signs     = signs_q;

  // Booth-encode the multiplier; triplet 111 maps to zero (no negative zero).
  always_comb begin
    bx    = {2'b00, bus.b, 1'b0};
    trip  = '0;
    dig_c = '0;
    for (int i = 0; i < ROWS; i++) begin
      trip         = bx[2*i +: 3];
      dig_c[i].neg = trip[2] & ~(trip[1] & trip[0]);
      dig_c[i].one = trip[1] ^ trip[0];
      dig_c[i].two = (trip == 3'b100) | (trip == 3'b011);
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    booth_row u_row (
      .a    (a_q),
      .dig  (dig_q[gi]),
      .row  (pp_c[gi]),
      .sign (signs_c[gi])
    );
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      a_q     <= '0;
      dig_q   <= '0;
      pp_q    <= '0;
      signs_q <= '0;
    end else begin
      if (in_xfer) begin
        v1_q  <= 1'b1;
        a_q   <= bus.a;
        dig_q <= dig_c;
      end else if (adv2) begin
        v1_q <= 1'b0;
      end
      if (adv2) begin
        v2_q    <= 1'b1;
        pp_q    <= pp_c;
        signs_q <= signs_c;
      end else if (out_xfer) begin
        v2_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mbe_pp_gen.sv
// Scoreboard bench for mbe_pp_gen: directed vectors plus a random stream.
module tb_mbe_pp_gen;
  import mod_dadda_mul_pkg::*;

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    bit            exact;
    pp_t           pp;
    signs_t        signs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  bit   rnd_on = 1'b0;
  exp_t q[$];

  mbe_pp_gen_if bus ();

  mbe_pp_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic longint sum_rows(input pp_t p, input signs_t s);
    longint acc = 0;
    longint r;
    for (int i = 0; i < ROWS; i++) begin
      r = longint'({39'b0, p[i]});
      if (s[i]) r = -(longint'(33554431) - r);
      acc += r <<< (2 * i);
    end
    return acc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a set is transferred out.
  initial begin
    exp_t e;
    longint prod;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got pp=%h with empty scoreboard", bus.pp);
        end else begin
          e = q.pop_front();
          prod = longint'({40'b0, e.a}) * longint'({40'b0, e.b});
          if (sum_rows(bus.pp, bus.signs) != prod) begin
            errors++;
            $display("FAIL invariant a=%h b=%h: got %0d expected %0d", e.a, e.b,
                     sum_rows(bus.pp, bus.signs), prod);
          end
          if (e.exact) begin
            checks++;
            if (bus.pp !== e.pp || bus.signs !== e.signs) begin
              errors++;
              $display("FAIL rows a=%h b=%h: got signs=%h pp=%h expected signs=%h pp=%h",
                       e.a, e.b, bus.signs, bus.pp, e.signs, e.pp);
            end
          end
        end
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [NB-1:0] av, input logic [NB-1:0] bv, input bit push,
                      input bit exact, input pp_t epp, input signs_t esg);
    int n = 0;
    exp_t e;
    bit ok = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n > 300) begin
        ok = 1'b0;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      e.a = av; e.b = bv; e.exact = exact; e.pp = epp; e.signs = esg;
      if (push) q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      accepted++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  pp_t    e1, e2, e3, e4, snap_pp;
  signs_t snap_sg;

  initial begin
    e1 = '0; e1[0] = 25'h0000001;
    e2 = '0; e2[0] = 25'h1FFFFF5; e2[1] = 25'h0000005;
    e3 = '0; e3[0] = 25'h1000000; e3[12] = 25'h0FFFFFF;
    e4 = '0; e4[1] = 25'h0000003;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_signs", 64'(bus.signs), 64'd0);
    chk("reset_pp_zero", 64'(bus.pp == '0), 64'd1);
    @(posedge clk);
    #1;

    // Latency: in_valid driven, accepted at next edge, out_valid after one more.
    send(24'h000001, 24'h000001, 1'b1, 1'b1, e1, 13'h0000);
    @(negedge clk);
    chk("latency_not_early", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("latency_on_time", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;

    send(24'h000005, 24'h000002, 1'b1, 1'b1, e2, 13'h0001);
    send(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, e3, 13'h0001);
    send(24'h000003, 24'h000004, 1'b1, 1'b1, e4, 13'h0000);
    drain();

    // Backpressure: four sets against a stalled output.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        send(24'h000001, 24'h000001, 1'b1, 1'b1, e1, 13'h0000);
        send(24'h000005, 24'h000002, 1'b1, 1'b1, e2, 13'h0001);
        send(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, e3, 13'h0001);
        send(24'h000003, 24'h000004, 1'b1, 1'b1, e4, 13'h0000);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        snap_pp = bus.pp;
        snap_sg = bus.signs;
        repeat (5) @(negedge clk);
        chk("stall_accepted", 64'(accepted), 64'd2);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_pp_stable", 64'(bus.pp == snap_pp), 64'd1);
        chk("stall_signs_stable", 64'(bus.signs), 64'(snap_sg));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_total_accepted", 64'(accepted), 64'd4);

    // Random stream with random in_valid gaps and out_ready.
    rnd_on = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(24'($urandom), 24'($urandom), 1'b1, 1'b0, '0, '0);
    end
    @(posedge clk);
    #1;
    rnd_on = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset with both stages full: in-flight sets must vanish.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(24'h123456, 24'h654321, 1'b0, 1'b0, '0, '0);
    send(24'hABCDEF, 24'h00FF00, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_pp_zero", 64'(bus.pp == '0), 64'd1);
    chk("rst_mid_signs", 64'(bus.signs), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
